// File: rtl/gnn_0_example_weight_banked.sv
// Weight loader: one 96-bit instruction triggers one DRAM read; the returned 512-bit lines are
// written into NUM_BANKS weight-buffer banks in broadcast, single-bank or stripe order.
module gnn_0_example_weight_banked #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int INST_LENGTH        = 96,
   parameter int NUM_BANKS          = 4,
   parameter int BUF_ADDR_WIDTH     = 9
) (
   input  logic                          kernel_clk,
   input  logic                          kernel_rst,
   input  logic                          ap_start,
   output logic                          ap_ready,
   output logic                          ap_done,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
   input  logic [INST_LENGTH-1:0]        ctrl_instruction,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
   output logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
   output logic                          read_start,
   input  logic                          read_done,
   input  logic                          data_tvalid,
   output logic                          data_tready,
   input  logic                          data_tlast,
   input  logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata,
   output logic [NUM_BANKS-1:0]          wbuf_valid,
   output logic [BUF_ADDR_WIDTH-1:0]     wbuf_addr,
   output logic [C_M_AXI_DATA_WIDTH-1:0] wbuf_data,
   output logic                          err_tlast
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_STREAM, ST_DONE} state_t;

   localparam logic [15:0] NB16 = 16'(NUM_BANKS);

   state_t                          state_r, state_next_s;
   logic [15:0]                     num_lines_r, buf_start_r, beats_r, beats_next_s;
   logic [1:0]                      mode_r;
   logic [3:0]                      bank_id_r;
   logic                            rd_seen_r;
   logic                            ap_ready_r, ap_done_r, read_start_r, tready_r, err_tlast_r;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   xfer_addr_r;
   logic [C_XFER_SIZE_WIDTH-1:0]    xfer_size_r;
   logic [NUM_BANKS-1:0]            wbuf_valid_r, mask_s;
   logic [BUF_ADDR_WIDTH-1:0]       wbuf_addr_r, addr_s;
   logic [C_M_AXI_DATA_WIDTH-1:0]   wbuf_data_r;
   logic                            beat_s, last_beat_s;
   logic [15:0]                     bank_k_s, stripe_row_s, bank_sel_s;
   logic                            unused_s;

   assign unused_s = ^ctrl_instruction[25:0];

   assign ap_ready                = ap_ready_r;
   assign ap_done                 = ap_done_r;
   assign read_start              = read_start_r;
   assign data_tready             = tready_r;
   assign dram_xfer_start_addr    = xfer_addr_r;
   assign dram_xfer_size_in_bytes = xfer_size_r;
   assign wbuf_valid              = wbuf_valid_r;
   assign wbuf_addr               = wbuf_addr_r;
   assign wbuf_data               = wbuf_data_r;
   assign err_tlast               = err_tlast_r;

   // Beat accounting and next-state decode; the last beat and read_done may land in either order
   always_comb begin
      beat_s       = data_tvalid & tready_r;
      beats_next_s = beats_r + {15'd0, beat_s};
      last_beat_s  = (beats_next_s == num_lines_r);
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (ap_start) state_next_s = ST_REQ;
            else          state_next_s = ST_IDLE;
         end
         ST_REQ: begin
            if (num_lines_r == 16'd0) state_next_s = ST_DONE;
            else                      state_next_s = ST_STREAM;
         end
         ST_STREAM: begin
            if (last_beat_s && (rd_seen_r || read_done)) state_next_s = ST_DONE;
            else                                         state_next_s = ST_STREAM;
         end
         ST_DONE: state_next_s = ST_IDLE;
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Bank mask and buffer address for beat index k = beats_r, wrapping modulo the buffer depth
   always_comb begin
      bank_k_s     = beats_r % NB16;
      stripe_row_s = beats_r / NB16;
      bank_sel_s   = {12'd0, bank_id_r} % NB16;
      case (mode_r)
         2'd0: begin
            mask_s = {NUM_BANKS{1'b1}};
            addr_s = BUF_ADDR_WIDTH'(buf_start_r + beats_r);
         end
         2'd2: begin
            mask_s = NUM_BANKS'(1'b1) << bank_k_s;
            addr_s = BUF_ADDR_WIDTH'(buf_start_r + stripe_row_s);
         end
         default: begin
            mask_s = NUM_BANKS'(1'b1) << bank_sel_s;
            addr_s = BUF_ADDR_WIDTH'(buf_start_r + beats_r);
         end
      endcase
   end

   // Control FSM, instruction latch, registered handshakes and the one-cycle-late write port
   always_ff @(posedge kernel_clk) begin
      if (kernel_rst) begin
         state_r      <= ST_IDLE;
         num_lines_r  <= 16'd0;
         buf_start_r  <= 16'd0;
         beats_r      <= 16'd0;
         mode_r       <= 2'd0;
         bank_id_r    <= 4'd0;
         rd_seen_r    <= 1'b0;
         ap_ready_r   <= 1'b1;
         ap_done_r    <= 1'b0;
         read_start_r <= 1'b0;
         tready_r     <= 1'b0;
         err_tlast_r  <= 1'b0;
         xfer_addr_r  <= {C_M_AXI_ADDR_WIDTH{1'b0}};
         xfer_size_r  <= {C_XFER_SIZE_WIDTH{1'b0}};
         wbuf_valid_r <= {NUM_BANKS{1'b0}};
         wbuf_addr_r  <= {BUF_ADDR_WIDTH{1'b0}};
         wbuf_data_r  <= {C_M_AXI_DATA_WIDTH{1'b0}};
      end else begin
         state_r      <= state_next_s;
         ap_ready_r   <= (state_next_s == ST_IDLE);
         ap_done_r    <= (state_next_s == ST_DONE);
         tready_r     <= (state_next_s == ST_STREAM) && (beats_next_s < num_lines_r);
         read_start_r <= (state_r == ST_IDLE) && ap_start && (ctrl_instruction[63:48] != 16'd0);
         if ((state_r == ST_IDLE) && ap_start) begin
            num_lines_r <= ctrl_instruction[63:48];
            buf_start_r <= ctrl_instruction[47:32];
            mode_r      <= ctrl_instruction[31:30];
            bank_id_r   <= ctrl_instruction[29:26];
            beats_r     <= 16'd0;
            rd_seen_r   <= 1'b0;
            xfer_addr_r <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'({ctrl_instruction[95:64], 6'd0});
            xfer_size_r <= C_XFER_SIZE_WIDTH'({ctrl_instruction[63:48], 6'd0});
         end else if (state_r == ST_DONE) begin
            xfer_addr_r <= {C_M_AXI_ADDR_WIDTH{1'b0}};
            xfer_size_r <= {C_XFER_SIZE_WIDTH{1'b0}};
         end else begin
            beats_r <= beats_next_s;
            if (((state_r == ST_REQ) || (state_r == ST_STREAM)) && read_done) rd_seen_r <= 1'b1;
         end
         if (beat_s) begin
            wbuf_valid_r <= mask_s;
            wbuf_addr_r  <= addr_s;
            wbuf_data_r  <= data_tdata;
            if (data_tlast != last_beat_s) err_tlast_r <= 1'b1;
         end else begin
            wbuf_valid_r <= {NUM_BANKS{1'b0}};
         end
      end
   end

endmodule

// File: tb/tb_gnn_0_example_weight_banked.sv
// Directed bench for the banked weight loader: broadcast, stripe, single-bank wrap, read_done
// ordering, empty instruction, tlast error, mid-transfer reset and busy ap_start.
module tb_gnn_0_example_weight_banked;

   logic         kernel_clk = 1'b0;
   logic         kernel_rst = 1'b1;
   logic         ap_start = 1'b0, ap_ready, ap_done;
   logic [63:0]  ctrl_addr_offset = 64'd0;
   logic [95:0]  ctrl_instruction = 96'd0;
   logic [63:0]  dram_xfer_start_addr;
   logic [31:0]  dram_xfer_size_in_bytes;
   logic         read_start, read_done = 1'b0;
   logic         data_tvalid = 1'b0, data_tready, data_tlast = 1'b0;
   logic [511:0] data_tdata = 512'd0;
   logic [3:0]   wbuf_valid;
   logic [8:0]   wbuf_addr;
   logic [511:0] wbuf_data;
   logic         err_tlast;

   gnn_0_example_weight_banked dut (
      .kernel_clk(kernel_clk), .kernel_rst(kernel_rst),
      .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
      .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
      .dram_xfer_start_addr(dram_xfer_start_addr), .dram_xfer_size_in_bytes(dram_xfer_size_in_bytes),
      .read_start(read_start), .read_done(read_done),
      .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tlast(data_tlast),
      .data_tdata(data_tdata),
      .wbuf_valid(wbuf_valid), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
      .err_tlast(err_tlast)
   );

   always #5 kernel_clk = ~kernel_clk;

   int n_checks = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, done_cyc = 0, rs_cnt = 0;
   int acc_cyc, rd_edge, last_beat_cyc, base;
   logic        rdy_at_done = 1'b0;
   logic [63:0] cap_addr = 64'd0, cap_size = 64'd0;
   logic [3:0]  wv_q[$];
   logic [8:0]  wa_q[$];
   logic [63:0] wd_q[$];

   always @(posedge kernel_clk) cyc <= cyc + 1;

   // Output monitor, sampled mid-cycle
   always @(negedge kernel_clk) begin
      if (ap_done === 1'b1) begin
         done_cnt    <= done_cnt + 1;
         done_cyc    <= cyc;
         rdy_at_done <= ap_ready;
      end
      if (read_start === 1'b1) begin
         rs_cnt   <= rs_cnt + 1;
         cap_addr <= dram_xfer_start_addr;
         cap_size <= 64'(dram_xfer_size_in_bytes);
      end
      if (!$isunknown(wbuf_valid) && wbuf_valid != 4'b0000) begin
         wv_q.push_back(wbuf_valid);
         wa_q.push_back(wbuf_addr);
         wd_q.push_back(wbuf_data[63:0]);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge kernel_clk);
      #1;
   endtask

   function automatic logic [95:0] mk_inst(input logic [31:0] li, input logic [15:0] n,
                                           input logic [15:0] bs, input logic [1:0] m,
                                           input logic [3:0] b);
      return {li, n, bs, m, b, 26'd0};
   endfunction

   task automatic issue(input logic [63:0] off, input logic [95:0] inst);
      ctrl_addr_offset = off;
      ctrl_instruction = inst;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic send_beat(input logic [63:0] w, input logic last);
      int n = 0;
      data_tvalid = 1'b1;
      data_tdata  = {8{w}};
      data_tlast  = last;
      @(negedge kernel_clk);
      while (data_tready !== 1'b1 && n < 40) begin
         @(negedge kernel_clk);
         n++;
      end
      check_eq("beat_handshake", 64'(data_tready), 64'd1);
      @(posedge kernel_clk);
      #1;
      data_tvalid = 1'b0;
      data_tlast  = 1'b0;
      last_beat_cyc = cyc;
   endtask

   task automatic pulse_rd();
      read_done = 1'b1;
      tick();
      read_done = 1'b0;
      rd_edge = cyc;
   endtask

   task automatic wait_done(input int b);
      int n = 0;
      while (done_cnt == b && n < 60) begin
         tick();
         n++;
      end
      check_eq("ap_done_seen", 64'(done_cnt - b), 64'd1);
   endtask

   task automatic exp_write(input string tag, input logic [3:0] v, input logic [8:0] a,
                            input logic [63:0] d);
      if (wv_q.size() > 0) begin
         check_eq({tag, "_valid"}, 64'(wv_q.pop_front()), 64'(v));
         check_eq({tag, "_addr"}, 64'(wa_q.pop_front()), 64'(a));
         check_eq({tag, "_data"}, wd_q.pop_front(), d);
      end
   endtask

   initial begin
      int bank_t[8];
      int addr_t[8];
      bank_t = '{1, 2, 4, 8, 1, 2, 4, 8};
      addr_t = '{5, 5, 5, 5, 6, 6, 6, 6};
      repeat (3) tick();
      kernel_rst = 1'b0;
      tick();
      check_eq("rst_ap_ready", 64'(ap_ready), 64'd1);
      check_eq("rst_outputs", 64'({ap_done, read_start, data_tready, err_tlast, wbuf_valid}), 64'd0);
      check_eq("rst_xfer_addr", dram_xfer_start_addr, 64'd0);

      // T1 broadcast, read_done after the last beat
      base = done_cnt;
      issue(64'h1000, mk_inst(32'd2, 16'd2, 16'd0, 2'd0, 4'd0));
      send_beat(64'h11, 1'b0);
      send_beat(64'h12, 1'b1);
      pulse_rd();
      wait_done(base);
      check_eq("t1_done_timing", 64'(done_cyc), 64'(rd_edge));
      check_eq("t1_ready_low_at_done", 64'(rdy_at_done), 64'd0);
      check_eq("t1_ready_after", 64'(ap_ready), 64'd1);
      check_eq("t1_read_starts", 64'(rs_cnt), 64'd1);
      check_eq("t1_xfer_addr", cap_addr, 64'h1080);
      check_eq("t1_xfer_size", cap_size, 64'd128);
      check_eq("t1_n_writes", 64'(wv_q.size()), 64'd2);
      exp_write("t1_w0", 4'b1111, 9'd0, 64'h11);
      exp_write("t1_w1", 4'b1111, 9'd1, 64'h12);
      repeat (2) tick();
      check_eq("t1_done_pulse_len", 64'(done_cnt - base), 64'd1);

      // T2 stripe
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd8, 16'd5, 2'd2, 4'd0));
      for (int i = 0; i < 8; i++) send_beat(64'h200 + 64'(i), i == 7);
      pulse_rd();
      wait_done(base);
      check_eq("t2_n_writes", 64'(wv_q.size()), 64'd8);
      for (int i = 0; i < 8; i++)
         exp_write($sformatf("t2_w%0d", i), 4'(bank_t[i]), 9'(addr_t[i]), 64'h200 + 64'(i));

      // T3 single bank with address wrap and tvalid gaps
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd4, 16'd510, 2'd1, 4'd2));
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         send_beat(64'h300 + 64'(i), i == 3);
      end
      pulse_rd();
      wait_done(base);
      check_eq("t3_n_writes", 64'(wv_q.size()), 64'd4);
      exp_write("t3_w0", 4'b0100, 9'd510, 64'h300);
      exp_write("t3_w1", 4'b0100, 9'd511, 64'h301);
      exp_write("t3_w2", 4'b0100, 9'd0, 64'h302);
      exp_write("t3_w3", 4'b0100, 9'd1, 64'h303);

      // T4a read_done three cycles before the last beat
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd4, 16'd100, 2'd0, 4'd0));
      for (int i = 0; i < 3; i++) send_beat(64'h400 + 64'(i), 1'b0);
      pulse_rd();
      repeat (2) tick();
      check_eq("t4a_no_early_done", 64'(done_cnt - base), 64'd0);
      send_beat(64'h403, 1'b1);
      wait_done(base);
      check_eq("t4a_done_timing", 64'(done_cyc), 64'(last_beat_cyc));
      check_eq("t4a_n_writes", 64'(wv_q.size()), 64'd4);
      wv_q.delete(); wa_q.delete(); wd_q.delete();

      // T4b read_done five cycles after the last beat
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd2, 16'd0, 2'd0, 4'd0));
      send_beat(64'h410, 1'b0);
      send_beat(64'h411, 1'b1);
      repeat (4) tick();
      check_eq("t4b_no_early_done", 64'(done_cnt - base), 64'd0);
      pulse_rd();
      check_eq("t4b_rd_offset", 64'(rd_edge - last_beat_cyc), 64'd5);
      wait_done(base);
      check_eq("t4b_done_timing", 64'(done_cyc), 64'(rd_edge));
      wv_q.delete(); wa_q.delete(); wd_q.delete();
      check_eq("t4_err_clear", 64'(err_tlast), 64'd0);

      // T5a empty instruction
      base = done_cnt;
      issue(64'h0, mk_inst(32'd7, 16'd0, 16'd0, 2'd0, 4'd0));
      wait_done(base);
      check_eq("t5a_done_timing", 64'(done_cyc - acc_cyc), 64'd1);
      check_eq("t5a_no_read_start", 64'(rs_cnt), 64'd5);
      check_eq("t5a_ready", 64'(ap_ready), 64'd1);

      // T5b early tlast
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd4, 16'd40, 2'd0, 4'd0));
      for (int i = 0; i < 4; i++) send_beat(64'h500 + 64'(i), i == 2);
      pulse_rd();
      wait_done(base);
      check_eq("t5b_err_tlast", 64'(err_tlast), 64'd1);
      check_eq("t5b_n_writes", 64'(wv_q.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         exp_write($sformatf("t5b_w%0d", i), 4'b1111, 9'(40 + i), 64'h500 + 64'(i));

      // T6 busy ap_start ignored, reset mid-transfer, then a clean instruction
      base = done_cnt;
      issue(64'h2000, mk_inst(32'd1, 16'd16, 16'd0, 2'd0, 4'd0));
      send_beat(64'h600, 1'b0);
      ctrl_addr_offset = 64'h9000;
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      check_eq("t6_busy_addr", dram_xfer_start_addr, 64'h2040);
      check_eq("t6_busy_read_starts", 64'(rs_cnt), 64'd7);
      send_beat(64'h601, 1'b0);
      kernel_rst = 1'b1;
      repeat (2) tick();
      wv_q.delete(); wa_q.delete(); wd_q.delete();
      kernel_rst = 1'b0;
      data_tvalid = 1'b1;
      repeat (6) tick();
      data_tvalid = 1'b0;
      check_eq("t6_no_writes", 64'(wv_q.size()), 64'd0);
      check_eq("t6_no_done", 64'(done_cnt - base), 64'd0);
      check_eq("t6_tready", 64'(data_tready), 64'd0);
      check_eq("t6_ready", 64'(ap_ready), 64'd1);
      check_eq("t6_err_cleared", 64'(err_tlast), 64'd0);
      issue(64'h0, mk_inst(32'd3, 16'd2, 16'd20, 2'd3, 4'd7));
      send_beat(64'h610, 1'b0);
      send_beat(64'h611, 1'b1);
      pulse_rd();
      wait_done(base);
      check_eq("t6_xfer_addr", cap_addr, 64'hC0);
      check_eq("t6_n_writes", 64'(wv_q.size()), 64'd2);
      exp_write("t6_w0", 4'b1000, 9'd20, 64'h610);
      exp_write("t6_w1", 4'b1000, 9'd21, 64'h611);
      // back-to-back accept right after DONE
      base = done_cnt;
      issue(64'h0, mk_inst(32'd0, 16'd0, 16'd0, 2'd0, 4'd0));
      wait_done(base);
      check_eq("t6_b2b_timing", 64'(done_cyc - acc_cyc), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
